// File: rtl/seg_pwm_dimmer.sv
// Multi-channel PWM dimmer: gates each active-low seven-segment bus with a per-channel PWM.
// Period/duty are shadowed and only take effect at period boundaries; continuous or one-shot.
module seg_pwm_dimmer #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 28,
  parameter int SEG_W    = 8
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [CHANNELS*CNT_W-1:0] period_i,
  input  logic [CHANNELS*CNT_W-1:0] decode_i,
  input  logic [CHANNELS*SEG_W-1:0] seg_i,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS-1:0]       oneshot_i,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic [CHANNELS*SEG_W-1:0] seg_o,
  output logic [CHANNELS-1:0]       wrap_o,
  output logic [CHANNELS-1:0]       done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_duty;
    logic             r_mode;
    logic             r_pwm;
    logic             r_wrap;
    logic             r_done;
    logic [SEG_W-1:0] r_seg;

    logic [CNT_W-1:0] w_per_in;
    logic [CNT_W-1:0] w_duty_in;
    logic [SEG_W-1:0] w_seg_in;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_en;
    logic             w_wrap;
    logic             w_pwm_nxt;

    assign w_per_in  = period_i[g*CNT_W +: CNT_W];
    assign w_duty_in = decode_i[g*CNT_W +: CNT_W];
    assign w_seg_in  = seg_i[g*SEG_W +: SEG_W];
    assign w_en      = enable_i[g];
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // r_per is never zero in RUN, so the subtraction cannot underflow here
    assign w_wrap    = (r_state == S_RUN) && (r_cnt == r_per - CNT_W'(1));

    // seg_o must follow the pwm value being registered, so it is computed ahead of the flop
    always_comb begin
      w_pwm_nxt = 1'b0;
      case (r_state)
        S_IDLE: w_pwm_nxt = w_en && (w_per_in != '0) && (w_duty_in != '0);
        S_RUN: begin
          if (w_en) begin
            if (w_wrap) w_pwm_nxt = !r_mode && (w_per_in != '0) && (w_duty_in != '0);
            else        w_pwm_nxt = (w_cnt_inc < r_duty);
          end
        end
        default: w_pwm_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_per   <= '0;
        r_duty  <= '0;
        r_mode  <= 1'b0;
        r_pwm   <= 1'b0;
        r_seg   <= '1;
        r_wrap  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_pwm  <= w_pwm_nxt;
        r_seg  <= w_pwm_nxt ? w_seg_in : '1;
        r_wrap <= 1'b0;
        r_done <= 1'b0;
        case (r_state)
          S_IDLE: begin
            r_per  <= w_per_in;
            r_duty <= w_duty_in;
            r_cnt  <= '0;
            if (w_en && (w_per_in != '0)) begin
              r_state <= S_RUN;
              r_mode  <= oneshot_i[g];
            end
          end
          S_RUN: begin
            // disable wins over a coincident wrap: no pulse, straight back to IDLE
            if (!w_en) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else if (w_wrap) begin
              r_wrap <= 1'b1;
              r_cnt  <= '0;
              r_per  <= w_per_in;
              r_duty <= w_duty_in;
              if (r_mode) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else if (w_per_in == '0) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_DONE: begin
            r_cnt <= '0;
            if (!w_en) r_state <= S_IDLE;
            else       r_done  <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign pwm_o[g]                 = r_pwm;
    assign seg_o[g*SEG_W +: SEG_W]  = r_seg;
    assign wrap_o[g]                = r_wrap;
    assign done_o[g]                = r_done;
  end

endmodule

// File: tb/tb_seg_pwm_dimmer.sv
// Self-checking bench for seg_pwm_dimmer: directed scenarios plus randomized traffic,
// all compared each cycle against a position/duty reference model.
module tb_seg_pwm_dimmer;
  localparam int CH    = 4;
  localparam int CNT_W = 28;
  localparam int SEG_W = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic                   clk_clk = 1'b0;
  logic                   reset_reset;
  logic [CH*CNT_W-1:0]    period_i;
  logic [CH*CNT_W-1:0]    decode_i;
  logic [CH*SEG_W-1:0]    seg_i;
  logic [CH-1:0]          enable_i;
  logic [CH-1:0]          oneshot_i;
  logic [CH-1:0]          pwm_o;
  logic [CH*SEG_W-1:0]    seg_o;
  logic [CH-1:0]          wrap_o;
  logic [CH-1:0]          done_o;

  seg_pwm_dimmer #(.CHANNELS(CH), .CNT_W(CNT_W), .SEG_W(SEG_W)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .period_i    (period_i),
    .decode_i    (decode_i),
    .seg_i       (seg_i),
    .enable_i    (enable_i),
    .oneshot_i   (oneshot_i),
    .pwm_o       (pwm_o),
    .seg_o       (seg_o),
    .wrap_o      (wrap_o),
    .done_o      (done_o)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a running channel sits at a position within its period;
  // the output is high while position < duty.
  int               m_st   [CH];
  logic [CNT_W-1:0] m_pos  [CH];
  logic [CNT_W-1:0] m_per  [CH];
  logic [CNT_W-1:0] m_duty [CH];
  logic             m_one  [CH];
  logic [CH-1:0]       e_pwm, e_wrap, e_done;
  logic [CH*SEG_W-1:0] e_seg;

  task automatic model_step();
    logic [CNT_W-1:0] p, d;
    logic             on;
    for (int c = 0; c < CH; c++) begin
      p = period_i[c*CNT_W +: CNT_W];
      d = decode_i[c*CNT_W +: CNT_W];
      if (reset_reset) begin
        m_st[c] = M_IDLE; m_pos[c] = '0; m_per[c] = '0; m_duty[c] = '0; m_one[c] = 1'b0;
        e_wrap[c] = 1'b0;
      end else begin
        e_wrap[c] = 1'b0;
        case (m_st[c])
          M_IDLE: begin
            m_per[c] = p; m_duty[c] = d; m_pos[c] = '0;
            if (enable_i[c] && p != 0) begin m_st[c] = M_RUN; m_one[c] = oneshot_i[c]; end
          end
          M_RUN: begin
            if (!enable_i[c]) begin
              m_st[c] = M_IDLE; m_pos[c] = '0;
            end else if (m_pos[c] == m_per[c] - 1) begin
              e_wrap[c] = 1'b1; m_pos[c] = '0; m_per[c] = p; m_duty[c] = d;
              if (m_one[c]) m_st[c] = M_DONE;
              else if (p == 0) m_st[c] = M_IDLE;
            end else begin
              m_pos[c] = m_pos[c] + 1;
            end
          end
          default: if (!enable_i[c]) m_st[c] = M_IDLE;
        endcase
      end
      on = (m_st[c] == M_RUN) && (m_pos[c] < m_duty[c]);
      e_pwm[c]  = on;
      e_done[c] = (m_st[c] == M_DONE);
      e_seg[c*SEG_W +: SEG_W] = on ? seg_i[c*SEG_W +: SEG_W] : {SEG_W{1'b1}};
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_clk);
    #1;
    check("pwm_o",  64'(pwm_o),  64'(e_pwm));
    check("seg_o",  64'(seg_o),  64'(e_seg));
    check("wrap_o", 64'(wrap_o), 64'(e_wrap));
    check("done_o", 64'(done_o), 64'(e_done));
  endtask

  task automatic set_ch(input int c, input int p, input int d, input int s);
    period_i[c*CNT_W +: CNT_W] = CNT_W'(p);
    decode_i[c*CNT_W +: CNT_W] = CNT_W'(d);
    seg_i[c*SEG_W +: SEG_W]    = SEG_W'(s);
  endtask

  initial begin
    int hi;
    bit found;
    reset_reset = 1'b1;
    period_i = '0; decode_i = '0; seg_i = '0;
    enable_i = '1; oneshot_i = '0;
    for (int c = 0; c < CH; c++) set_ch(c, 3 + c, 2, 8'h11 * c);
    #1;

    // reset held with enable high
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("rst_pwm", 64'(pwm_o), 64'(0));
      check("rst_seg", 64'(seg_o), {32'h0, 32'hFFFF_FFFF});
    end
    enable_i = '0;
    reset_reset = 1'b0;
    cycle();

    // continuous ch0: P=4, D=1
    set_ch(0, 4, 1, 8'hC0);
    enable_i[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("ch0_seg",  64'(seg_o[7:0]), (k % 4 == 0) ? 64'hC0 : 64'hFF);
      check("ch0_wrap", 64'(wrap_o[0]), 64'((k % 4 == 0) && (k > 0)));
    end

    // shadowing ch1: duty change at cnt=3 applies to the next period only
    set_ch(1, 10, 5, 8'h3F);
    enable_i[1] = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (k == 3) decode_i[1*CNT_W +: CNT_W] = CNT_W'(8);
      if (pwm_o[1]) hi++;
      if (k == 9)  begin check("ch1_hi_p1", 64'(hi), 64'(5)); hi = 0; end
      if (k == 19) check("ch1_hi_p2", 64'(hi), 64'(8));
    end
    for (int k = 0; k < 4; k++) cycle();
    period_i[1*CNT_W +: CNT_W] = '0;
    for (int k = 0; k < 12; k++) cycle();
    check("ch1_idle_pwm", 64'(pwm_o[1]), 64'(0));

    // one-shot ch2: P=6, D=6
    set_ch(2, 6, 6, 8'h06);
    oneshot_i[2] = 1'b1;
    enable_i[2]  = 1'b1;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (pwm_o[2]) hi++;
    end
    check("ch2_hi", 64'(hi), 64'(6));
    check("ch2_done", 64'(done_o[2]), 64'(1));
    enable_i[2] = 1'b0;
    cycle(); cycle();
    enable_i[2] = 1'b1;
    for (int k = 0; k < 9; k++) cycle();
    enable_i[2] = 1'b0;
    oneshot_i[2] = 1'b0;
    cycle();

    // boundaries on ch3
    set_ch(3, 1, 1, 8'h5A);
    enable_i[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("p1_pwm", 64'(pwm_o[3]), 64'(1));
      if (k > 0) check("p1_wrap", 64'(wrap_o[3]), 64'(1));
    end
    decode_i[3*CNT_W +: CNT_W] = '0;
    for (int k = 0; k < 4; k++) cycle();
    check("d0_pwm", 64'(pwm_o[3]), 64'(0));
    set_ch(3, 3, 32'h0FFF_FFFF, 8'h77);
    for (int k = 0; k < 7; k++) cycle();
    check("dmax_pwm", 64'(pwm_o[3]), 64'(1));
    decode_i[3*CNT_W +: CNT_W] = CNT_W'(2);
    for (int k = 0; k < 4; k++) cycle();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (m_st[3] == M_RUN && m_pos[3] == m_per[3] - 1) begin
        enable_i[3] = 1'b0;
        found = 1'b1;
        cycle();
        check("drop_nowrap", 64'(wrap_o[3]), 64'(0));
        check("drop_pwm", 64'(pwm_o[3]), 64'(0));
      end else begin
        cycle();
      end
    end
    check("drop_found", 64'(found), 64'(1));

    // randomized traffic on all channels with a mid-run reset
    for (int c = 0; c < CH; c++) set_ch(c, 2 + 3 * c, 1 + c, $urandom);
    enable_i = '1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        int c;
        c = $urandom_range(0, CH - 1);
        set_ch(c, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 9),
               ($urandom_range(0, 9) == 0) ? 32'h0FFF_FFFF : $urandom_range(0, 11),
               $urandom);
      end
      if ($urandom_range(0, 15) == 0) enable_i[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) oneshot_i = CH'($urandom);
      reset_reset = (k >= 200 && k < 202);
      cycle();
      if (k == 201) check("mid_rst_pwm", 64'(pwm_o), 64'(0));
    end
    reset_reset = 1'b1;
    cycle();
    check("end_rst_seg", 64'(seg_o), {32'h0, 32'hFFFF_FFFF});
    check("end_rst_done", 64'(done_o), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
